// File: rtl/fp_unit_sequencer_if.sv
// rtl/fp_unit_sequencer_if.sv - type package and bus interface for the FP unit sequencer
//
// Package fp_unit_sequencer_pkg: sub-unit selector and command types shared by
// the request side and the execution unit side.
//
// Interface fp_unit_sequencer_if groups every non-clock/reset signal:
//   flush              pipeline flush
//   req*               request channel (valid/ready) with unit, command, operands
//   fpu*               execution-unit drive (enable/flush/operands) and return (results/flags/done)
//   resp*              response channel (valid/ready) with results, flags, timeout
//   fflagsClear/Accum  sticky exception flag control/state
// Modports: slave = sequencer, master = its environment.

package fp_unit_sequencer_pkg;
  typedef enum logic [2:0] {
    FP_MOVE       = 3'd0,
    FP_CLASSIFIER = 3'd1,
    FP_SIGN       = 3'd2,
    FP_COMPARATOR = 3'd3,
    FP_MULADD     = 3'd4,
    FP_DIV        = 3'd5,
    FP_SQRT       = 3'd6
  } FpUnitType;

  typedef logic [3:0] FpUnitCommand;
endpackage

interface fp_unit_sequencer_if;
  import fp_unit_sequencer_pkg::*;

  logic         flush;

  logic         reqValid;
  logic         reqReady;
  FpUnitType    reqUnit;
  FpUnitCommand reqCommand;
  logic [2:0]   reqRoundingMode;
  logic [31:0]  reqIntSrc1;
  logic [31:0]  reqFpSrc1;
  logic [31:0]  reqFpSrc2;
  logic [31:0]  reqFpSrc3;

  logic         fpuEnable;
  logic         fpuFlush;
  FpUnitType    fpuUnit;
  FpUnitCommand fpuCommand;
  logic [2:0]   fpuRoundingMode;
  logic [31:0]  fpuIntSrc1;
  logic [31:0]  fpuFpSrc1;
  logic [31:0]  fpuFpSrc2;
  logic [31:0]  fpuFpSrc3;
  logic [31:0]  fpuIntResult;
  logic [31:0]  fpuFpResult;
  logic         fpuWriteFlags;
  logic [4:0]   fpuFlagsValue;
  logic         fpuDone;

  logic         respValid;
  logic         respReady;
  logic [31:0]  respIntResult;
  logic [31:0]  respFpResult;
  logic         respWriteFlags;
  logic [4:0]   respFlags;
  logic         respTimeout;

  logic         fflagsClear;
  logic [4:0]   fflagsAccum;

  modport slave (
    input  flush,
    input  reqValid, reqUnit, reqCommand, reqRoundingMode,
    input  reqIntSrc1, reqFpSrc1, reqFpSrc2, reqFpSrc3,
    output reqReady,
    output fpuEnable, fpuFlush, fpuUnit, fpuCommand, fpuRoundingMode,
    output fpuIntSrc1, fpuFpSrc1, fpuFpSrc2, fpuFpSrc3,
    input  fpuIntResult, fpuFpResult, fpuWriteFlags, fpuFlagsValue, fpuDone,
    output respValid, respIntResult, respFpResult, respWriteFlags, respFlags, respTimeout,
    input  respReady,
    input  fflagsClear,
    output fflagsAccum
  );

  modport master (
    output flush,
    output reqValid, reqUnit, reqCommand, reqRoundingMode,
    output reqIntSrc1, reqFpSrc1, reqFpSrc2, reqFpSrc3,
    input  reqReady,
    input  fpuEnable, fpuFlush, fpuUnit, fpuCommand, fpuRoundingMode,
    input  fpuIntSrc1, fpuFpSrc1, fpuFpSrc2, fpuFpSrc3,
    output fpuIntResult, fpuFpResult, fpuWriteFlags, fpuFlagsValue, fpuDone,
    input  respValid, respIntResult, respFpResult, respWriteFlags, respFlags, respTimeout,
    output respReady,
    output fflagsClear,
    input  fflagsAccum
  );
endinterface

// File: rtl/fp_unit_sequencer.sv
// rtl/fp_unit_sequencer.sv - single-outstanding-operation controller for the FP32 execution unit
//
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  fp_unit_sequencer_if.slave: request channel in, execution-unit drive
//        and return, response channel out, sticky flag clear/accumulator.
// Parameters:
//   TIMEOUT_CYCLES  EXEC cycles allowed before the watchdog aborts (2..255)
//   CNT_W           EXEC counter width, 2**CNT_W > TIMEOUT_CYCLES

module fp_unit_sequencer
  import fp_unit_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  fp_unit_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  FpUnitType          unit_q, unit_d;
  FpUnitCommand       cmd_q, cmd_d;
  logic [2:0]         rm_q, rm_d;
  logic [31:0]        int_src_q, int_src_d;
  logic [31:0]        fp_src1_q, fp_src1_d;
  logic [31:0]        fp_src2_q, fp_src2_d;
  logic [31:0]        fp_src3_q, fp_src3_d;
  logic [31:0]        resp_int_q, resp_int_d;
  logic [31:0]        resp_fp_q, resp_fp_d;
  logic               resp_wf_q, resp_wf_d;
  logic [4:0]         resp_flags_q, resp_flags_d;
  logic               resp_to_q, resp_to_d;
  logic [4:0]         fflags_q, fflags_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      unit_q       <= FP_MOVE;
      cmd_q        <= '0;
      rm_q         <= '0;
      int_src_q    <= '0;
      fp_src1_q    <= '0;
      fp_src2_q    <= '0;
      fp_src3_q    <= '0;
      resp_int_q   <= '0;
      resp_fp_q    <= '0;
      resp_wf_q    <= 1'b0;
      resp_flags_q <= '0;
      resp_to_q    <= 1'b0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      unit_q       <= unit_d;
      cmd_q        <= cmd_d;
      rm_q         <= rm_d;
      int_src_q    <= int_src_d;
      fp_src1_q    <= fp_src1_d;
      fp_src2_q    <= fp_src2_d;
      fp_src3_q    <= fp_src3_d;
      resp_int_q   <= resp_int_d;
      resp_fp_q    <= resp_fp_d;
      resp_wf_q    <= resp_wf_d;
      resp_flags_q <= resp_flags_d;
      resp_to_q    <= resp_to_d;
      fflags_q     <= fflags_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    unit_d        = unit_q;
    cmd_d         = cmd_q;
    rm_d          = rm_q;
    int_src_d     = int_src_q;
    fp_src1_d     = fp_src1_q;
    fp_src2_d     = fp_src2_q;
    fp_src3_d     = fp_src3_q;
    resp_int_d    = resp_int_q;
    resp_fp_d     = resp_fp_q;
    resp_wf_d     = resp_wf_q;
    resp_flags_d  = resp_flags_q;
    resp_to_d     = resp_to_q;
    bus.reqReady  = 1'b0;
    bus.fpuEnable = 1'b0;
    bus.fpuFlush  = 1'b0;
    bus.respValid = 1'b0;
    // Clear is applied first so a same-cycle commit lands on an empty accumulator.
    fflags_d      = bus.fflagsClear ? 5'b0 : fflags_q;

    unique case (state_q)
      S_IDLE: begin
        // Ready is held low while reset is asserted, since state is already IDLE then.
        bus.reqReady = rst && !bus.flush;
        if (bus.reqValid && !bus.flush) begin
          unit_d    = bus.reqUnit;
          cmd_d     = bus.reqCommand;
          rm_d      = bus.reqRoundingMode;
          int_src_d = bus.reqIntSrc1;
          fp_src1_d = bus.reqFpSrc1;
          fp_src2_d = bus.reqFpSrc2;
          fp_src3_d = bus.reqFpSrc3;
          cnt_d     = '0;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        // Priority: external flush, then unit done, then watchdog.
        if (bus.flush) begin
          bus.fpuFlush = 1'b1;
          state_d      = S_IDLE;
        end else begin
          bus.fpuEnable = 1'b1;
          if (bus.fpuDone) begin
            resp_int_d   = bus.fpuIntResult;
            resp_fp_d    = bus.fpuFpResult;
            resp_wf_d    = bus.fpuWriteFlags;
            resp_flags_d = bus.fpuFlagsValue;
            resp_to_d    = 1'b0;
            state_d      = S_RESP;
          end else begin
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
            if (cnt_q == CNT_LAST) begin
              bus.fpuFlush = 1'b1;
              resp_int_d   = '0;
              resp_fp_d    = '0;
              resp_wf_d    = 1'b0;
              resp_flags_d = '0;
              resp_to_d    = 1'b1;
              state_d      = S_RESP;
            end
          end
        end
      end

      S_RESP: begin
        bus.respValid = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.respReady) begin
          state_d = S_IDLE;
          if (resp_wf_q && !resp_to_q) begin
            fflags_d = fflags_d | resp_flags_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.fpuUnit         = unit_q;
  assign bus.fpuCommand      = cmd_q;
  assign bus.fpuRoundingMode = rm_q;
  assign bus.fpuIntSrc1      = int_src_q;
  assign bus.fpuFpSrc1       = fp_src1_q;
  assign bus.fpuFpSrc2       = fp_src2_q;
  assign bus.fpuFpSrc3       = fp_src3_q;
  assign bus.respIntResult   = resp_int_q;
  assign bus.respFpResult    = resp_fp_q;
  assign bus.respWriteFlags  = resp_wf_q;
  assign bus.respFlags       = resp_flags_q;
  assign bus.respTimeout     = resp_to_q;
  assign bus.fflagsAccum     = fflags_q;

endmodule
